// File: rtl/apb_regfile_slave.sv
// APB-style register-file slave: parametrised RW / W1C / RO bit map, byte strobes,
// programmable wait states, error response, sticky hardware-set bits and interrupt.
module apb_regfile_slave #(
  parameter int unsigned              ADDRW       = 32,
  parameter int unsigned              DATAW       = 32,
  parameter int unsigned              NREGS       = 16,
  parameter logic [ADDRW-1:0]         BASE_ADDR   = '0,
  parameter int unsigned              WAIT_STATES = 0,
  parameter logic [NREGS*DATAW-1:0]   RST_VAL     = '0,
  parameter logic [NREGS*DATAW-1:0]   RW_MASK     = '1,
  parameter logic [NREGS*DATAW-1:0]   W1C_MASK    = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDRW-1:0]         addr_i,
  input  logic                     write_i,
  input  logic                     sel_i,
  input  logic                     enable_i,
  input  logic [DATAW-1:0]         wdata_i,
  input  logic [DATAW/8-1:0]       strb_i,
  output logic [DATAW-1:0]         rdata_o,
  output logic                     ready_o,
  output logic                     slverr_o,
  input  logic [NREGS*DATAW-1:0]   ro_in_i,
  input  logic [NREGS*DATAW-1:0]   hw_set_i,
  output logic [NREGS*DATAW-1:0]   reg_q_o,
  output logic [NREGS-1:0]         wr_pulse_o,
  output logic                     irq_o
);

  localparam int unsigned NB   = DATAW / 8;
  localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned RegW = NREGS * DATAW;

  // W1C takes precedence over RW; bits in neither mask are RO and never stored.
  localparam logic [RegW-1:0] W1cEff    = W1C_MASK;
  localparam logic [RegW-1:0] RwEff     = RW_MASK & ~W1C_MASK;
  localparam logic [RegW-1:0] StoreMask = RW_MASK | W1C_MASK;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               write_q;
  logic               err_q;
  logic [IdxW-1:0]    idx_q;
  logic [DATAW-1:0]   wdata_q;
  logic [NB-1:0]      strb_q;
  logic [DATAW-1:0]   rdata_q;
  logic               slverr_q;
  logic [NREGS-1:0]   wr_pulse_q;
  logic [RegW-1:0]    regs_q;
  logic [RegW-1:0]    regs_d;

  logic [ADDRW:0]     diff;
  logic [ADDRW-1:0]   offset;
  logic               dec_err;
  logic [IdxW-1:0]    dec_idx;

  // Borrow bit of the extended subtraction flags addr below BASE_ADDR.
  always_comb begin
    diff    = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    offset  = diff[ADDRW-1:0];
    dec_err = diff[ADDRW] || ((offset % ADDRW'(NB)) != '0) ||
              ((offset / ADDRW'(NB)) >= ADDRW'(NREGS));
    dec_idx = IdxW'(offset / ADDRW'(NB));
  end

  logic [RegW-1:0]  rd_all;
  logic [IdxW-1:0]  rd_idx;
  logic             rd_err;
  logic [DATAW-1:0] rd_word;

  // With zero wait states RESP is entered straight from IDLE, so use the live decode there.
  always_comb begin
    rd_all  = (regs_q & StoreMask) | (ro_in_i & ~StoreMask);
    rd_idx  = (state_q == StIdle) ? dec_idx : idx_q;
    rd_err  = (state_q == StIdle) ? dec_err : err_q;
    rd_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_idx == IdxW'(i)) rd_word = rd_all[i*DATAW +: DATAW];
    end
    if (rd_err) rd_word = '0;
  end

  logic             commit;
  logic [DATAW-1:0] bmask;

  assign commit = (state_q == StResp) && sel_i && enable_i;

  always_comb begin
    bmask = '0;
    for (int k = 0; k < NB; k++) bmask[k*8 +: 8] = {8{strb_q[k]}};
    regs_d = regs_q;
    if (commit && write_q && !err_q) begin
      for (int i = 0; i < NREGS; i++) begin
        if (idx_q == IdxW'(i)) begin
          regs_d[i*DATAW +: DATAW] =
              (regs_q[i*DATAW +: DATAW] & ~(bmask & RwEff[i*DATAW +: DATAW])) |
              (wdata_q & bmask & RwEff[i*DATAW +: DATAW]);
          regs_d[i*DATAW +: DATAW] = regs_d[i*DATAW +: DATAW] &
                                     ~(wdata_q & bmask & W1cEff[i*DATAW +: DATAW]);
        end
      end
    end
    // Hardware set is applied last so it wins over a coincident software clear.
    regs_d = regs_d | (hw_set_i & W1cEff);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      wr_pulse_q <= '0;
      regs_q     <= RST_VAL & StoreMask;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (sel_i && !enable_i) begin
            write_q <= write_i;
            err_q   <= dec_err;
            idx_q   <= dec_idx;
            wdata_q <= wdata_i;
            strb_q  <= strb_i;
            if (WAIT_STATES == 0) begin
              state_q  <= StResp;
              rdata_q  <= write_i ? '0 : rd_word;
              slverr_q <= dec_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        StWait: begin
          if (!sel_i) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd1) begin
            state_q  <= StResp;
            rdata_q  <= write_q ? '0 : rd_word;
            slverr_q <= err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (!sel_i || enable_i) begin
            state_q  <= StIdle;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            if (sel_i && write_q && !err_q) wr_pulse_q[idx_q] <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o    = (state_q == StResp);
  assign rdata_o    = rdata_q;
  assign slverr_o   = slverr_q;
  assign reg_q_o    = regs_q;
  assign wr_pulse_o = wr_pulse_q;
  assign irq_o      = |(regs_q & W1cEff);

endmodule
